// File: rtl/pifo_sched_ctrl.sv
// pifo_sched_ctrl: round-robin ingress arbiter onto the PIFO insert port plus a one-entry registered egress stage.
// Optional feature macro PIFO_SCHED_STATS_EN: activity counters and source-port tagging in meta[L2_NUM_PORTS-1:0].
module pifo_sched_ctrl #(
    parameter int NUM_PORTS    = 4,
    parameter int RANK_WIDTH   = 10,
    parameter int META_WIDTH   = 20,
    parameter int L2_NUM_PORTS = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_PORTS-1:0]            enq_valid,
    output logic [NUM_PORTS-1:0]            enq_ready,
    input  logic [NUM_PORTS*RANK_WIDTH-1:0] enq_rank,
    input  logic [NUM_PORTS*META_WIDTH-1:0] enq_meta,
    output logic                            pifo_insert,
    output logic                            pifo_remove,
    output logic [RANK_WIDTH-1:0]           pifo_rank_in,
    output logic [META_WIDTH-1:0]           pifo_meta_in,
    input  logic [RANK_WIDTH-1:0]           pifo_rank_out,
    input  logic [META_WIDTH-1:0]           pifo_meta_out,
    input  logic                            pifo_valid_out,
    input  logic                            pifo_busy,
    input  logic                            pifo_full,
    input  logic                            deq_pause,
    output logic                            deq_valid,
    input  logic                            deq_ready,
    output logic [RANK_WIDTH-1:0]           deq_rank,
    output logic [META_WIDTH-1:0]           deq_meta,
    output logic [L2_NUM_PORTS-1:0]         deq_src_port
`ifdef PIFO_SCHED_STATS_EN
    ,
    output logic [31:0]                     stat_enq_cnt,
    output logic [31:0]                     stat_deq_cnt,
    output logic [31:0]                     stat_stall_cnt
`endif
);

    typedef enum logic {OUT_EMPTY, OUT_FULL} out_state_t;

    out_state_t              state;
    logic [L2_NUM_PORTS-1:0] rr_ptr;
    logic [L2_NUM_PORTS-1:0] grant;
    logic [L2_NUM_PORTS-1:0] scan_port;
    int unsigned             scan_idx;
    logic                    found;
    logic                    any_valid;
    logic                    pop;
    logic                    can_ins;
    logic [RANK_WIDTH-1:0]   sel_rank;
    logic [META_WIDTH-1:0]   sel_meta;
    logic [L2_NUM_PORTS-1:0] src_tag;

    assign any_valid   = |enq_valid;
    assign pop         = pifo_valid_out & ~deq_pause & ((state == OUT_EMPTY) | deq_ready);
    // Remove has strict priority over insert on the shared PIFO port.
    assign can_ins     = ~pifo_busy & ~pifo_full & ~pop & ~rst;
    assign pifo_remove = pop & ~rst;
    assign pifo_insert = any_valid & can_ins;

    always_comb begin
        grant     = '0;
        found     = 1'b0;
        scan_idx  = 0;
        scan_port = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            scan_idx = 32'(rr_ptr) + i;
            if (scan_idx >= NUM_PORTS) begin
                scan_idx = scan_idx - NUM_PORTS;
            end
            scan_port = L2_NUM_PORTS'(scan_idx);
            if (!found && enq_valid[scan_port]) begin
                found = 1'b1;
                grant = scan_port;
            end
        end
    end

    always_comb begin
        sel_rank = '0;
        sel_meta = '0;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            if (grant == L2_NUM_PORTS'(p)) begin
                sel_rank = enq_rank[p*RANK_WIDTH +: RANK_WIDTH];
                sel_meta = enq_meta[p*META_WIDTH +: META_WIDTH];
            end
        end
`ifdef PIFO_SCHED_STATS_EN
        sel_meta[L2_NUM_PORTS-1:0] = grant;
`endif
    end

    always_comb begin
        enq_ready = '0;
        if (pifo_insert) begin
            enq_ready[grant] = 1'b1;
        end
    end

    assign pifo_rank_in = (any_valid & ~rst) ? sel_rank : '0;
    assign pifo_meta_in = (any_valid & ~rst) ? sel_meta : '0;

`ifdef PIFO_SCHED_STATS_EN
    assign src_tag = pifo_meta_out[L2_NUM_PORTS-1:0];
`else
    assign src_tag = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (pifo_insert) begin
            rr_ptr <= (grant == L2_NUM_PORTS'(NUM_PORTS - 1)) ? '0 : grant + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= OUT_EMPTY;
            deq_valid    <= 1'b0;
            deq_rank     <= '0;
            deq_meta     <= '0;
            deq_src_port <= '0;
        end else begin
            case (state)
                OUT_EMPTY: begin
                    if (pop) begin
                        state        <= OUT_FULL;
                        deq_valid    <= 1'b1;
                        deq_rank     <= pifo_rank_out;
                        deq_meta     <= pifo_meta_out;
                        deq_src_port <= src_tag;
                    end
                end
                OUT_FULL: begin
                    if (pop) begin
                        deq_rank     <= pifo_rank_out;
                        deq_meta     <= pifo_meta_out;
                        deq_src_port <= src_tag;
                    end else if (deq_ready) begin
                        state     <= OUT_EMPTY;
                        deq_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= OUT_EMPTY;
                    deq_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef PIFO_SCHED_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_enq_cnt   <= '0;
            stat_deq_cnt   <= '0;
            stat_stall_cnt <= '0;
        end else begin
            if (pifo_insert) stat_enq_cnt <= stat_enq_cnt + 32'd1;
            if (pop) stat_deq_cnt <= stat_deq_cnt + 32'd1;
            if (any_valid & ~can_ins) stat_stall_cnt <= stat_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pifo_sched_ctrl.sv
// tb_pifo_sched_ctrl: directed scenarios plus randomized traffic against a queue-level reference model.
module tb_pifo_sched_ctrl;
    localparam int NP = 4;
    localparam int RW = 10;
    localparam int MW = 20;
    localparam int LW = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic [NP-1:0]    enq_valid;
    logic [NP-1:0]    enq_ready;
    logic [NP*RW-1:0] enq_rank;
    logic [NP*MW-1:0] enq_meta;
    logic             pifo_insert, pifo_remove;
    logic [RW-1:0]    pifo_rank_in, pifo_rank_out;
    logic [MW-1:0]    pifo_meta_in, pifo_meta_out;
    logic             pifo_valid_out, pifo_busy, pifo_full, deq_pause;
    logic             deq_valid, deq_ready;
    logic [RW-1:0]    deq_rank;
    logic [MW-1:0]    deq_meta;
    logic [LW-1:0]    deq_src_port;
`ifdef PIFO_SCHED_STATS_EN
    logic [31:0]      stat_enq_cnt, stat_deq_cnt, stat_stall_cnt;
`endif

    logic [RW-1:0]    t_rank [NP];
    logic [MW-1:0]    t_meta [NP];

    int vectors = 0;
    int miscompares = 0;

    for (genvar g = 0; g < NP; g++) begin : g_pack
        assign enq_rank[g*RW +: RW] = t_rank[g];
        assign enq_meta[g*MW +: MW] = t_meta[g];
    end

    always #5 clk = ~clk;

    pifo_sched_ctrl #(.NUM_PORTS(NP), .RANK_WIDTH(RW), .META_WIDTH(MW), .L2_NUM_PORTS(LW)) dut (
        .clk(clk), .rst(rst),
        .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_rank(enq_rank), .enq_meta(enq_meta),
        .pifo_insert(pifo_insert), .pifo_remove(pifo_remove),
        .pifo_rank_in(pifo_rank_in), .pifo_meta_in(pifo_meta_in),
        .pifo_rank_out(pifo_rank_out), .pifo_meta_out(pifo_meta_out), .pifo_valid_out(pifo_valid_out),
        .pifo_busy(pifo_busy), .pifo_full(pifo_full), .deq_pause(deq_pause),
        .deq_valid(deq_valid), .deq_ready(deq_ready), .deq_rank(deq_rank), .deq_meta(deq_meta),
        .deq_src_port(deq_src_port)
`ifdef PIFO_SCHED_STATS_EN
        , .stat_enq_cnt(stat_enq_cnt), .stat_deq_cnt(stat_deq_cnt), .stat_stall_cnt(stat_stall_cnt)
`endif
    );

    // Meta as the PIFO should see it after the controller's optional source tagging.
    function automatic logic [MW-1:0] exp_meta(input logic [MW-1:0] m, input int p);
        logic [MW-1:0] r;
        r = m;
`ifdef PIFO_SCHED_STATS_EN
        r[LW-1:0] = LW'(p);
`else
        if (p < 0) r = '0;
`endif
        return r;
    endfunction

    function automatic logic [LW-1:0] exp_src(input logic [MW-1:0] m);
`ifdef PIFO_SCHED_STATS_EN
        return m[LW-1:0];
`else
        return (m === m) ? '0 : '1;
`endif
    endfunction

    function automatic int model_grant(input logic [NP-1:0] v, input int rr);
        for (int k = 0; k < NP; k++) begin
            if (v[(rr + k) % NP]) return (rr + k) % NP;
        end
        return 0;
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        enq_valid = '0;
        for (int p = 0; p < NP; p++) begin
            t_rank[p] = '0;
            t_meta[p] = '0;
        end
        pifo_rank_out = '0; pifo_meta_out = '0; pifo_valid_out = 1'b0;
        pifo_busy = 1'b0; pifo_full = 1'b0; deq_pause = 1'b0; deq_ready = 1'b0;
    endtask

    task automatic test_reset;
        idle_inputs();
        rst = 1'b1;
        enq_valid = '1;
        pifo_valid_out = 1'b1;
        pifo_rank_out = 10'd5;
        step(); step();
        @(negedge clk);
        vectors++; if (enq_ready !== '0) begin miscompares++; $display("FAIL rst_enq_ready got=%b exp=0", enq_ready); end
        vectors++; if (pifo_insert !== 1'b0) begin miscompares++; $display("FAIL rst_insert got=%b exp=0", pifo_insert); end
        vectors++; if (pifo_remove !== 1'b0) begin miscompares++; $display("FAIL rst_remove got=%b exp=0", pifo_remove); end
        vectors++; if (pifo_rank_in !== '0) begin miscompares++; $display("FAIL rst_rank_in got=%0d exp=0", pifo_rank_in); end
        vectors++; if (deq_valid !== 1'b0) begin miscompares++; $display("FAIL rst_deq_valid got=%b exp=0", deq_valid); end
        vectors++; if ({deq_rank, deq_meta, deq_src_port} !== '0) begin miscompares++; $display("FAIL rst_deq_data got=%0d/%0d/%0d exp=0", deq_rank, deq_meta, deq_src_port); end
        step();
        rst = 1'b0;
        idle_inputs();
    endtask

    task automatic test_rr_order;
        enq_valid = 4'hF;
        for (int p = 0; p < NP; p++) begin
            t_rank[p] = RW'(100 + p);
            t_meta[p] = MW'(1000 + 16 * p);
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            vectors++; if (enq_ready !== NP'(1 << (k % NP))) begin miscompares++; $display("FAIL rr_ready k=%0d got=%b exp=%b", k, enq_ready, NP'(1 << (k % NP))); end
            vectors++; if (pifo_insert !== 1'b1) begin miscompares++; $display("FAIL rr_insert k=%0d got=%b exp=1", k, pifo_insert); end
            vectors++; if (pifo_rank_in !== RW'(100 + k % NP)) begin miscompares++; $display("FAIL rr_rank k=%0d got=%0d exp=%0d", k, pifo_rank_in, 100 + k % NP); end
            vectors++; if (pifo_meta_in !== exp_meta(MW'(1000 + 16 * (k % NP)), k % NP)) begin miscompares++; $display("FAIL rr_meta k=%0d got=%0h", k, pifo_meta_in); end
            step();
        end
        idle_inputs();
    endtask

    task automatic test_single_port;
        enq_valid = 4'b0100;
        t_rank[2] = 10'd37;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            vectors++; if (enq_ready !== 4'b0100) begin miscompares++; $display("FAIL single_ready k=%0d got=%b exp=0100", k, enq_ready); end
            vectors++; if (pifo_rank_in !== 10'd37) begin miscompares++; $display("FAIL single_rank k=%0d got=%0d exp=37", k, pifo_rank_in); end
            step();
        end
        idle_inputs();
    endtask

    task automatic test_busy;
        enq_valid = 4'b0010;
        t_rank[1] = 10'd55;
        pifo_busy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            vectors++; if ({enq_ready, pifo_insert} !== 5'b0) begin miscompares++; $display("FAIL busy_block k=%0d got=%b/%b exp=0/0", k, enq_ready, pifo_insert); end
            step();
        end
        pifo_busy = 1'b0;
        @(negedge clk);
        vectors++; if (enq_ready !== 4'b0010) begin miscompares++; $display("FAIL busy_release got=%b exp=0010", enq_ready); end
        vectors++; if (pifo_rank_in !== 10'd55) begin miscompares++; $display("FAIL busy_rank got=%0d exp=55", pifo_rank_in); end
        step();
        enq_valid = 4'b1001;
        @(negedge clk);
        vectors++; if (enq_ready !== 4'b1000) begin miscompares++; $display("FAIL busy_rr_next got=%b exp=1000", enq_ready); end
        step();
        idle_inputs();
    endtask

    task automatic test_pop_priority;
        pifo_valid_out = 1'b1; pifo_rank_out = 10'd5; pifo_meta_out = 20'h12343; deq_ready = 1'b1;
        enq_valid = 4'b0001; t_rank[0] = 10'd66;
        @(negedge clk);
        vectors++; if (pifo_remove !== 1'b1) begin miscompares++; $display("FAIL pop_remove got=%b exp=1", pifo_remove); end
        vectors++; if ({enq_ready, pifo_insert} !== 5'b0) begin miscompares++; $display("FAIL pop_blocks_ins got=%b/%b exp=0/0", enq_ready, pifo_insert); end
        step();
        pifo_valid_out = 1'b0;
        @(negedge clk);
        vectors++; if (deq_valid !== 1'b1 || deq_rank !== 10'd5) begin miscompares++; $display("FAIL pop_out got=%b/%0d exp=1/5", deq_valid, deq_rank); end
        vectors++; if (deq_meta !== 20'h12343 || deq_src_port !== exp_src(20'h12343)) begin miscompares++; $display("FAIL pop_meta got=%0h/%0d", deq_meta, deq_src_port); end
        vectors++; if (enq_ready !== 4'b0001) begin miscompares++; $display("FAIL pop_then_ins got=%b exp=0001", enq_ready); end
        step();
        enq_valid = '0;
        @(negedge clk);
        vectors++; if (deq_valid !== 1'b0) begin miscompares++; $display("FAIL pop_drain got=%b exp=0", deq_valid); end
        step();
        idle_inputs();
    endtask

    task automatic test_hold_reload;
        pifo_valid_out = 1'b1; pifo_rank_out = 10'd7; pifo_meta_out = 20'd70;
        @(negedge clk);
        vectors++; if (pifo_remove !== 1'b1) begin miscompares++; $display("FAIL hold_fill got=%b exp=1", pifo_remove); end
        step();
        pifo_rank_out = 10'd9; pifo_meta_out = 20'd90;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            vectors++; if (pifo_remove !== 1'b0) begin miscompares++; $display("FAIL hold_noremove k=%0d got=%b exp=0", k, pifo_remove); end
            vectors++; if (deq_valid !== 1'b1 || deq_rank !== 10'd7) begin miscompares++; $display("FAIL hold_data k=%0d got=%b/%0d exp=1/7", k, deq_valid, deq_rank); end
            step();
        end
        deq_ready = 1'b1;
        @(negedge clk);
        vectors++; if (pifo_remove !== 1'b1) begin miscompares++; $display("FAIL reload_remove got=%b exp=1", pifo_remove); end
        step();
        pifo_valid_out = 1'b0; deq_ready = 1'b0;
        @(negedge clk);
        vectors++; if (deq_valid !== 1'b1 || deq_rank !== 10'd9) begin miscompares++; $display("FAIL reload_data got=%b/%0d exp=1/9", deq_valid, deq_rank); end
        step();
        deq_ready = 1'b1;
        step();
        @(negedge clk);
        vectors++; if (deq_valid !== 1'b0) begin miscompares++; $display("FAIL reload_drain got=%b exp=0", deq_valid); end
        step();
        idle_inputs();
    endtask

    task automatic test_pause_reset;
        pifo_valid_out = 1'b1; pifo_rank_out = 10'd3; pifo_meta_out = 20'd30;
        step();
        deq_pause = 1'b1; pifo_rank_out = 10'd4;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            vectors++; if (pifo_remove !== 1'b0) begin miscompares++; $display("FAIL pause_noremove k=%0d got=%b exp=0", k, pifo_remove); end
            vectors++; if (deq_valid !== 1'b1 || deq_rank !== 10'd3) begin miscompares++; $display("FAIL pause_hold k=%0d got=%b/%0d exp=1/3", k, deq_valid, deq_rank); end
            step();
        end
        deq_ready = 1'b1;
        step();
        @(negedge clk);
        vectors++; if (deq_valid !== 1'b0 || pifo_remove !== 1'b0) begin miscompares++; $display("FAIL pause_drain got=%b/%b exp=0/0", deq_valid, pifo_remove); end
        deq_pause = 1'b0; deq_ready = 1'b0;
        step();
        deq_pause = 1'b1;
        step();
        @(negedge clk);
        vectors++; if (deq_valid !== 1'b1 || deq_rank !== 10'd4) begin miscompares++; $display("FAIL pause_refill got=%b/%0d exp=1/4", deq_valid, deq_rank); end
        step();
        rst = 1'b1; enq_valid = 4'b0001;
        @(negedge clk);
        vectors++; if ({pifo_remove, pifo_insert} !== 2'b00) begin miscompares++; $display("FAIL rst_mid_ports got=%b exp=00", {pifo_remove, pifo_insert}); end
        step();
        rst = 1'b0;
        idle_inputs();
        @(negedge clk);
        vectors++; if (deq_valid !== 1'b0 || deq_rank !== '0) begin miscompares++; $display("FAIL rst_mid_out got=%b/%0d exp=0/0", deq_valid, deq_rank); end
`ifdef PIFO_SCHED_STATS_EN
        vectors++; if ({stat_enq_cnt, stat_deq_cnt, stat_stall_cnt} !== '0) begin miscompares++; $display("FAIL rst_counters got=%0d/%0d/%0d exp=0", stat_enq_cnt, stat_deq_cnt, stat_stall_cnt); end
`endif
        step();
    endtask

    task automatic test_random;
        int            m_rr;
        bit            m_full;
        logic [RW-1:0] m_rank;
        logic [MW-1:0] m_meta;
        logic [LW-1:0] m_src;
        logic [NP-1:0] accepted;
        logic [NP-1:0] e_ready;
        logic [31:0]   m_enq, m_deq, m_stall;
        bit            e_pop, e_can, e_ins, any;
        int            g;
        idle_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
        m_rr = 0; m_full = 0; m_rank = '0; m_meta = '0; m_src = '0; accepted = '0;
        m_enq = '0; m_deq = '0; m_stall = '0;
        for (int cyc = 0; cyc < 500; cyc++) begin
            for (int p = 0; p < NP; p++) begin
                if (accepted[p]) enq_valid[p] = 1'b0;
                if (!enq_valid[p] && ($urandom % 2 == 0)) begin
                    enq_valid[p] = 1'b1;
                    t_rank[p] = RW'($urandom);
                    t_meta[p] = MW'($urandom);
                end
            end
            pifo_busy = ($urandom % 4 == 0);
            pifo_full = ($urandom % 8 == 0);
            deq_pause = ($urandom % 5 == 0);
            deq_ready = ($urandom % 3 != 0);
            pifo_valid_out = ($urandom % 3 != 0);
            pifo_rank_out = RW'($urandom);
            pifo_meta_out = MW'($urandom);
            @(negedge clk);
            any   = |enq_valid;
            e_pop = pifo_valid_out && !deq_pause && (!m_full || deq_ready);
            e_can = !pifo_busy && !pifo_full && !e_pop;
            e_ins = any && e_can;
            g     = model_grant(enq_valid, m_rr);
            e_ready = '0;
            if (e_ins) e_ready[g] = 1'b1;
            vectors++; if (pifo_remove !== e_pop) begin miscompares++; $display("FAIL rnd_remove cyc=%0d got=%b exp=%b", cyc, pifo_remove, e_pop); end
            vectors++; if (pifo_insert !== e_ins) begin miscompares++; $display("FAIL rnd_insert cyc=%0d got=%b exp=%b", cyc, pifo_insert, e_ins); end
            vectors++; if (enq_ready !== e_ready) begin miscompares++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", cyc, enq_ready, e_ready); end
            vectors++; if (pifo_rank_in !== (any ? t_rank[g] : '0)) begin miscompares++; $display("FAIL rnd_rank_in cyc=%0d got=%0d", cyc, pifo_rank_in); end
            vectors++; if (pifo_meta_in !== (any ? exp_meta(t_meta[g], g) : '0)) begin miscompares++; $display("FAIL rnd_meta_in cyc=%0d got=%0h", cyc, pifo_meta_in); end
            vectors++; if (deq_valid !== m_full) begin miscompares++; $display("FAIL rnd_deq_valid cyc=%0d got=%b exp=%b", cyc, deq_valid, m_full); end
            if (m_full) begin
                vectors++; if ({deq_rank, deq_meta, deq_src_port} !== {m_rank, m_meta, m_src}) begin miscompares++; $display("FAIL rnd_deq_data cyc=%0d got=%0d/%0h/%0d exp=%0d/%0h/%0d", cyc, deq_rank, deq_meta, deq_src_port, m_rank, m_meta, m_src); end
            end
`ifdef PIFO_SCHED_STATS_EN
            vectors++; if ({stat_enq_cnt, stat_deq_cnt, stat_stall_cnt} !== {m_enq, m_deq, m_stall}) begin miscompares++; $display("FAIL rnd_counters cyc=%0d got=%0d/%0d/%0d exp=%0d/%0d/%0d", cyc, stat_enq_cnt, stat_deq_cnt, stat_stall_cnt, m_enq, m_deq, m_stall); end
`endif
            accepted = e_ready;
            if (e_ins) begin
                m_rr = (g + 1) % NP;
                m_enq++;
            end
            if (any && !e_can) m_stall++;
            if (e_pop) begin
                m_full = 1; m_rank = pifo_rank_out; m_meta = pifo_meta_out; m_src = exp_src(pifo_meta_out);
                m_deq++;
            end else if (m_full && deq_ready) begin
                m_full = 0;
            end
            step();
        end
        idle_inputs();
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_rr_order();
        test_single_port();
        test_busy();
        test_pop_priority();
        test_hold_reload();
        test_pause_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout exceeded bound");
        $fatal(1, "bench did not complete");
    end

endmodule
